tri_fu_mul_bthdcd_pipe: RTL and testbench

//  Pipelined radix-4 Booth recoder sitting directly upstream of the Booth mux array.

---
 rtl/tri_fu_mul_bthdcd_pipe.sv | 110 +++++++++++
 tb/tb_tri_fu_mul_bthdcd_pipe.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/tri_fu_mul_bthdcd_pipe.sv
// rtl/tri_fu_mul_bthdcd_pipe.sv - two-stage radix-4 Booth recoder feeding the Booth mux rows
module tri_fu_mul_bthdcd_pipe #(
  parameter int WIDTH  = 54,
  parameter int TAG_W  = 4,
  localparam int DIGITS = WIDTH / 2 + 1
) (
  input  logic              nclk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [WIDTH-1:0]  in_y,
  input  logic              in_signed,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_vld,
  input  logic              out_stall,
  output logic [DIGITS-1:0] out_sneg,
  output logic [DIGITS-1:0] out_sx,
  output logic [DIGITS-1:0] out_sx2,
  output logic [DIGITS-1:0] out_hot1,
  output logic [TAG_W-1:0]  out_tag
);

  // S1 capture registers; the operand is held sign/zero extended by two bits
  // so the top digit sees the extension and unsigned operands gain a +1 digit.
  logic               s1_vld;
  logic [WIDTH+1:0]   s1_y;
  logic [TAG_W-1:0]   s1_tag;

  logic               s2_adv;
  logic               accept;
  logic               ext;

  // Decoded selects for the operand sitting in S1
  logic [WIDTH+2:0]   y_pad;
  logic [DIGITS-1:0]  d_sneg;
  logic [DIGITS-1:0]  d_sx;
  logic [DIGITS-1:0]  d_sx2;
  logic               b0;
  logic               b1;
  logic               b2;

  // S2 drains whenever it is empty or downstream is taking data; S1 accepts
  // when it is empty or will hand off this edge. Flush blocks the input port.
  assign s2_adv = ~out_vld | ~out_stall;
  assign in_rdy = ~flush & (~s1_vld | s2_adv);
  assign accept = in_vld & in_rdy;
  assign ext    = in_signed & in_y[WIDTH-1];

  // Radix-4 Booth recode of every overlapping 3-bit window of the captured operand
  always_comb begin
    y_pad  = {s1_y, 1'b0};
    d_sneg = '0;
    d_sx   = '0;
    d_sx2  = '0;
    b0     = 1'b0;
    b1     = 1'b0;
    b2     = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      b0        = y_pad[2*i];
      b1        = y_pad[2*i+1];
      b2        = y_pad[2*i+2];
      d_sx[i]   = b1 ^ b0;
      d_sx2[i]  = (b2 & ~b1 & ~b0) | (~b2 & b1 & b0);
      // 111 encodes zero, so it must not raise a negate (no -0 row carry-in)
      d_sneg[i] = b2 & ~(b1 & b0);
    end
  end

  // S1: capture operand and tag; flush wins over accept and hand-off
  always_ff @(posedge nclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_y   <= '0;
      s1_tag <= '0;
    end else if (flush) begin
      s1_vld <= 1'b0;
    end else if (accept) begin
      s1_vld <= 1'b1;
      s1_y   <= {ext, ext, in_y};
      s1_tag <= in_tag;
    end else if (s1_vld && s2_adv) begin
      s1_vld <= 1'b0;
    end
  end

  // S2: register decoded selects toward the mux rows; hold while stalled
  always_ff @(posedge nclk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_sneg <= '0;
      out_sx   <= '0;
      out_sx2  <= '0;
      out_hot1 <= '0;
      out_tag  <= '0;
    end else if (flush) begin
      out_vld <= 1'b0;
    end else if (s2_adv) begin
      out_vld <= s1_vld;
      if (s1_vld) begin
        out_sneg <= d_sneg;
        out_sx   <= d_sx;
        out_sx2  <= d_sx2;
        out_hot1 <= d_sneg;
        out_tag  <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_tri_fu_mul_bthdcd_pipe.sv
// tb/tb_tri_fu_mul_bthdcd_pipe.sv - scoreboard bench for the Booth recoder pipe
module tb_tri_fu_mul_bthdcd_pipe;

  localparam int W = 8;
  localparam int T = 4;
  localparam int D = W / 2 + 1;

  logic         nclk;
  logic         rst_n;
  logic         flush;
  logic         in_vld;
  logic         in_rdy;
  logic [W-1:0] in_y;
  logic         in_signed;
  logic [T-1:0] in_tag;
  logic         out_vld;
  logic         out_stall;
  logic [D-1:0] out_sneg;
  logic [D-1:0] out_sx;
  logic [D-1:0] out_sx2;
  logic [D-1:0] out_hot1;
  logic [T-1:0] out_tag;

  tri_fu_mul_bthdcd_pipe #(.WIDTH(W), .TAG_W(T)) dut (
    .nclk(nclk), .rst_n(rst_n), .flush(flush),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_y(in_y), .in_signed(in_signed), .in_tag(in_tag),
    .out_vld(out_vld), .out_stall(out_stall),
    .out_sneg(out_sneg), .out_sx(out_sx), .out_sx2(out_sx2), .out_hot1(out_hot1),
    .out_tag(out_tag)
  );

  initial nclk = 1'b0;
  always #5 nclk = ~nclk;

  typedef struct {
    logic [T-1:0] tag;
    longint       val;
    logic         exact;
    logic [D-1:0] sn;
    logic [D-1:0] sx;
    logic [D-1:0] sx2;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_out   = 0;

  // Rebuild the operand value from the presented Booth digits
  function automatic longint recon(input logic [D-1:0] sn, input logic [D-1:0] sx,
                                   input logic [D-1:0] sx2);
    longint acc = 0;
    longint wgt = 1;
    longint m;
    for (int i = 0; i < D; i++) begin
      m = sx[i] ? 1 : (sx2[i] ? 2 : 0);
      acc += (sn[i] ? -m : m) * wgt;
      wgt *= 4;
    end
    return acc;
  endfunction

  // One clock: drive inputs, record accept into the scoreboard, pop and check a consumed output
  task automatic step(input logic v, input logic [W-1:0] y, input logic sgn, input logic [T-1:0] tag,
                      input logic stall, input logic fl, input logic exact,
                      input logic [D-1:0] e_sn, input logic [D-1:0] e_sx, input logic [D-1:0] e_sx2);
    exp_t e;
    exp_t g;
    @(negedge nclk);
    in_vld = v; in_y = y; in_signed = sgn; in_tag = tag; out_stall = stall; flush = fl;
    #1;
    if (!fl && out_vld && !stall) begin
      n_out++;
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_output: got tag %0d, required no output", out_tag);
      end else begin
        n_pass++;
        g = sb.pop_front();
        n_total++;
        if (out_tag !== g.tag) $display("FAIL tag_order: got %0d required %0d", out_tag, g.tag);
        else n_pass++;
        n_total++;
        if (recon(out_sneg, out_sx, out_sx2) !== g.val)
          $display("FAIL digit_sum: got %0d required %0d", recon(out_sneg, out_sx, out_sx2), g.val);
        else n_pass++;
        n_total++;
        if ((out_sx & out_sx2) !== '0) $display("FAIL sx_sx2_exclusive: got %b required 0", out_sx & out_sx2);
        else n_pass++;
        n_total++;
        if (out_hot1 !== out_sneg) $display("FAIL hot1: got %b required %b", out_hot1, out_sneg);
        else n_pass++;
        n_total++;
        if ((out_sneg & ~(out_sx | out_sx2)) !== '0)
          $display("FAIL neg_zero: got %b required 0", out_sneg & ~(out_sx | out_sx2));
        else n_pass++;
        if (g.exact) begin
          n_total++;
          if ({out_sneg, out_sx, out_sx2} !== {g.sn, g.sx, g.sx2})
            $display("FAIL exact_digits: got sneg=%b sx=%b sx2=%b required sneg=%b sx=%b sx2=%b",
                     out_sneg, out_sx, out_sx2, g.sn, g.sx, g.sx2);
          else n_pass++;
        end
      end
    end
    if (!fl && v && in_rdy) begin
      e.tag = tag; e.exact = exact; e.sn = e_sn; e.sx = e_sx; e.sx2 = e_sx2;
      e.val = sgn ? longint'($signed(y)) : longint'(y);
      sb.push_back(e);
    end
    @(posedge nclk);
    if (fl) sb.delete();
  endtask

  task automatic idle(input logic stall);
    step(1'b0, '0, 1'b0, '0, stall, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) idle(1'b0);
    n_total++;
    if (sb.size() != 0) $display("FAIL drain_timeout: got %0d pending required 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_vld = 1'b0; in_y = '0; in_signed = 1'b0; in_tag = '0; out_stall = 1'b0;
    repeat (3) @(posedge nclk);
    #1;
    n_total++;
    if ({out_vld, out_sneg, out_sx, out_sx2, out_hot1, out_tag} !== '0)
      $display("FAIL reset_outputs: got %h required 0", {out_vld, out_sneg, out_sx, out_sx2, out_hot1, out_tag});
    else n_pass++;
    @(negedge nclk);
    rst_n = 1'b1;
    #1;
    n_total++;
    if (in_rdy !== 1'b1) $display("FAIL reset_in_rdy: got %b required 1", in_rdy);
    else n_pass++;
  endtask

  task automatic test_directed();
    step(1'b1, 8'h03, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 5'b00001, 5'b00011, 5'b00000);
    step(1'b1, 8'hFF, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 5'b00001, 5'b10001, 5'b00000);
    step(1'b1, 8'h80, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 5'b01000, 5'b00000, 5'b01000);
    step(1'b1, 8'h80, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1, 5'b01000, 5'b10000, 5'b01000);
    step(1'b1, 8'h7F, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step(1'b1, 8'h00, 1'b1, 4'd6, 1'b0, 1'b0, 1'b1, 5'b00000, 5'b00000, 5'b00000);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [3*D+T-1:0] snap;
    int base;
    base = n_out;
    step(1'b1, 8'h5A, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step(1'b1, 8'hA5, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    snap = {out_sneg, out_sx, out_sx2, out_tag};
    n_total++;
    if (out_vld !== 1'b1 || out_tag !== 4'd0) $display("FAIL b2b_first_out: got vld=%b tag=%0d required vld=1 tag=0", out_vld, out_tag);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 8'h33, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, '0, '0, '0);
      #1;
      n_total++;
      if (in_rdy !== 1'b0) $display("FAIL b2b_in_rdy_stall: got %b required 0", in_rdy);
      else n_pass++;
      n_total++;
      if (out_vld !== 1'b1 || {out_sneg, out_sx, out_sx2, out_tag} !== snap)
        $display("FAIL b2b_hold: got %h required %h", {out_sneg, out_sx, out_sx2, out_tag}, snap);
      else n_pass++;
    end
    step(1'b1, 8'h33, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    drain();
    n_total++;
    if (n_out - base !== 3) $display("FAIL b2b_count: got %0d required 3", n_out - base);
    else n_pass++;
  endtask

  task automatic test_flush();
    step(1'b1, 8'h11, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step(1'b1, 8'h22, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge nclk);
    in_vld = 1'b1; in_y = 8'h44; in_tag = 4'd7; out_stall = 1'b1; flush = 1'b1;
    #1;
    n_total++;
    if (in_rdy !== 1'b0) $display("FAIL flush_in_rdy: got %b required 0", in_rdy);
    else n_pass++;
    @(posedge nclk);
    sb.delete();
    @(negedge nclk);
    flush = 1'b0; in_vld = 1'b0; out_stall = 1'b0;
    #1;
    n_total++;
    if (out_vld !== 1'b0 || in_rdy !== 1'b1) $display("FAIL flush_state: got vld=%b rdy=%b required vld=0 rdy=1", out_vld, in_rdy);
    else n_pass++;
    @(posedge nclk);
    for (int c = 0; c < 4; c++) idle(1'b0);
    step(1'b1, 8'h03, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 5'b00001, 5'b00011, 5'b00000);
    drain();
  endtask

  task automatic test_reset_mid_op();
    step(1'b1, 8'h99, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step(1'b1, 8'h98, 1'b1, 4'd10, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge nclk);
    in_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (out_vld !== 1'b0) $display("FAIL async_reset: got %b required 0", out_vld);
    else n_pass++;
    sb.delete();
    @(negedge nclk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) idle(1'b0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 6000; c++)
      step($urandom_range(0, 9) < 8, W'($urandom), 1'($urandom), T'(c), $urandom_range(0, 9) < 3,
           1'b0, 1'b0, '0, '0, '0);
    drain();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
